my_ram_64_copier: RTL
=====================

# my_ram_64_copier

Block-transfer initiator that drives the single port of a 64-word × 16-bit RAM (`my_ram_64`) and copies a run of words from a source address to a destination address. It issues the combinational-read / clocked-write accesses that `my_ram_64` expects, handles overlapping regions and address wrap-around, and produces a running 16-bit checksum of the copied data. It sits between a controller (start/busy/done handshake) and the RAM's `addr`/`in`/`load`/`out` pins.

## Interface
- Parameters: none. Data width is fixed at 16 and address width at 6 to match the 64-word RAM.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a copy; sampled only in IDLE.
- `src`  input  6  first source address; sampled with `start`.
- `dst`  input  6  first destination address; sampled with `start`.
- `count`  input  7  number of words; 0..64, values above 64 are clamped to 64.
- `busy`  output  1  high in READ and WRITE.
- `done`  output  1  one-cycle pulse in the DONE state.
- `sum`  output  16  sum mod 2^16 of all words read in the current or last transfer.
- `mem_addr`  output  6  drives the RAM `addr`.
- `mem_wdata`  output  16  drives the RAM `in`.
- `mem_load`  output  1  drives the RAM `load`.
- `mem_rdata`  input  16  from the RAM `out` (combinational read).

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches `src`, `dst`, clamped count `n`, and direction, and clears `sum`.
  - If `n`=0, go to DONE; otherwise go to READ.
- Direction is decided at start.
  - Descending if `(dst − src) mod 64` lies in 1..n−1, i.e. forward overlap. Pointers then start at `src+n−1` and `dst+n−1` mod 64 and decrement.
  - Otherwise ascending: pointers start at `src` and `dst` and increment.
  - All pointer arithmetic is mod 64, so runs wrap from 63 to 0 (or from 0 to 63 when descending).
- READ:
  - `mem_addr`=rd_ptr, `mem_load`=0.
  - At the clock edge, `mem_rdata` is latched into the data register, `sum` += `mem_rdata`, and rd_ptr steps.
  - Next state: WRITE.
- WRITE:
  - `mem_addr`=wr_ptr, `mem_wdata`=data register, `mem_load`=1; the RAM writes at that edge.
  - wr_ptr steps and the remaining count decrements.
  - Next state: READ if words remain, else DONE.
- DONE: `done`=1 for one cycle, then IDLE. `sum` holds until the next accepted start.
- `start` outside IDLE is ignored, including in DONE.
- `src`==`dst` is a legal ascending copy; the RAM contents are unchanged and `sum` is still computed.
- `mem_addr`, `mem_load` and `mem_wdata` are decoded from registered state only, so they cannot glitch from the inputs.
- In IDLE and DONE: `mem_load`=0, `mem_addr`=0, `mem_wdata`=data register.

## Timing
- Reset (async, on `rst_n` low): state IDLE; `busy`=0, `done`=0, `sum`=0, `mem_load`=0, `mem_addr`=0, `mem_wdata`=0; pointers, count and data register all 0. Outputs change without waiting for a clock.
- Reset mid-transfer: `mem_load` drops immediately and no further writes occur. Words already written stay written. A new transfer needs a fresh `start` after `rst_n` rises.
- With `start` sampled at edge 0 and count `n` > 0:
  - `busy` is high for cycles 1..2n; READ and WRITE alternate, READ first.
  - `done` is high in cycle 2n+1; `busy` is 0 in that cycle.
  - `mem_load` is high for exactly `n` cycles.
- With `n`=0: `done` is high in cycle 1, no RAM access.
- Throughput: 2 cycles per word. Back-to-back transfers have a gap of 1 DONE cycle plus 1 IDLE cycle before the next start is sampled.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 -> all outputs 0, no `mem_load`. Release `rst_n` -> stays IDLE until the next sampled `start`.
- Basic copy: preload RAM[0..3]=1,2,3,4; `src`=0, `dst`=10, `count`=4 -> RAM[10..13]=1,2,3,4; `done` 9 cycles after start; `sum`=10; `mem_load` high for 4 cycles; RAM[0..3] unchanged.
- Forward overlap: RAM[0..4]=0xA,0xB,0xC,0xD,0xE; `src`=0, `dst`=2, `count`=5 -> write order 6,5,4,3,2; RAM[2..6]=0xA..0xE; `sum`=0x3C.
- Wrap and backward overlap:
  - RAM[62]=1, RAM[63]=2, RAM[0]=3, RAM[1]=4; `src`=62, `dst`=30, `count`=4 -> reads 62,63,0,1 in order; RAM[30..33]=1..4.
  - `src`=5, `dst`=3, `count`=4 -> ascending copy.
- Count edge cases:
  - `count`=0 -> `done` in cycle 1, `busy` never set, no write, `sum`=0.
  - `count`=100 -> exactly 64 words copied; `done` at cycle 129.
- Handshake and reset abort:
  - `start` pulsed again while `busy` -> ignored; the first transfer completes unchanged.
  - `rst_n` low during a WRITE cycle -> `mem_load` and `busy` drop at once; destination holds only the words written before that edge.

Source files
------------

// File: rtl/my_ram_64_copier_if.sv
// Controller + RAM-port bundle for my_ram_64_copier.
//
// Handshake: the controller raises start with src/dst/count valid; the
// copier samples them only while idle (busy=0, done=0). busy stays high
// while words are moving, and done pulses for exactly one cycle when the
// transfer ends. A start seen while busy or done is dropped, not queued.
interface my_ram_64_copier_if;
    logic        start;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  count;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_load;
    logic [15:0] mem_rdata;

    // Copier side: consumes the request and the RAM read data.
    modport master (
        input  start, src, dst, count, mem_rdata,
        output busy, done, sum, mem_addr, mem_wdata, mem_load
    );

    // Environment side: controller plus the RAM itself.
    modport slave (
        output start, src, dst, count, mem_rdata,
        input  busy, done, sum, mem_addr, mem_wdata, mem_load
    );
endinterface

// File: rtl/my_ram_64_copier.sv
// Block copier for a 64 x 16 single-port RAM with combinational read and
// clocked write. One word moves every two cycles (READ then WRITE).
// Overlapping runs where the destination lies ahead of the source are
// copied top-down so source words are read before they are overwritten.
module my_ram_64_copier (
    input  logic                   clk,
    input  logic                   rst_n,
    my_ram_64_copier_if.master     bus,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  rd_ptr;
    logic [5:0]  wr_ptr;
    logic [6:0]  remaining;
    logic [15:0] data_q;
    logic [15:0] sum_q;
    logic        descend;

    // Start-time decode of the request.
    logic [6:0]  n_clamp;
    logic [5:0]  n_last;
    logic [5:0]  diff;
    logic        desc_start;

    assign n_clamp    = (bus.count > 7'd64) ? 7'd64 : bus.count;
    // Offset of the last word in the run; for n=64 this wraps to 63.
    assign n_last     = n_clamp[5:0] - 6'd1;
    assign diff       = bus.dst - bus.src;
    // Destination starts inside the source run (ahead of src): copy downwards.
    assign desc_start = (diff != 6'd0) && ({1'b0, diff} < n_clamp);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (n_clamp == 7'd0) ? DONE : READ;
                end
            end
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (remaining == 7'd1) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: pointers, remaining count, data register and checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 6'd0;
            wr_ptr    <= 6'd0;
            remaining <= 7'd0;
            data_q    <= 16'd0;
            sum_q     <= 16'd0;
            descend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd_ptr    <= desc_start ? (bus.src + n_last) : bus.src;
                        wr_ptr    <= desc_start ? (bus.dst + n_last) : bus.dst;
                        remaining <= n_clamp;
                        descend   <= desc_start;
                        sum_q     <= 16'd0;
                    end
                end
                READ: begin
                    data_q <= bus.mem_rdata;
                    sum_q  <= sum_q + bus.mem_rdata;
                    rd_ptr <= descend ? (rd_ptr - 6'd1) : (rd_ptr + 6'd1);
                end
                WRITE: begin
                    wr_ptr    <= descend ? (wr_ptr - 6'd1) : (wr_ptr + 6'd1);
                    remaining <= remaining - 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only, so the RAM pins never
    // follow the request inputs combinationally.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.mem_load  = 1'b0;
        bus.mem_addr  = 6'd0;
        bus.mem_wdata = data_q;
        bus.sum       = sum_q;
        fsm_state     = state;
        case (state)
            READ: begin
                bus.busy     = 1'b1;
                bus.mem_addr = rd_ptr;
            end
            WRITE: begin
                bus.busy     = 1'b1;
                bus.mem_addr = wr_ptr;
                bus.mem_load = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
